// File: rtl/regfile_param.sv
// Parametrised register file: one synchronous byte-masked write port and two combinational read ports.
// Optional hardwired-zero entry 0 and optional write-to-read bypass.
module regfile_param #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 5,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wrenable,
    input  logic [ADDR_BITS-1:0]   writeaddr,
    input  logic [WIDTH-1:0]       writedata,
    input  logic [WIDTH/8-1:0]     byteenable,
    input  logic [ADDR_BITS-1:0]   readaddr1,
    input  logic [ADDR_BITS-1:0]   readaddr2,
    output logic [WIDTH-1:0]       readdata1,
    output logic [WIDTH-1:0]       readdata2
);

    localparam int DEPTH  = 1 << ADDR_BITS;
    localparam int NBYTES = WIDTH / 8;
    localparam bit ZR     = (ZERO_REG != 0);
    localparam bit BP     = (BYPASS != 0);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] wr_merged;
    logic             wr_live;

    assign wr_live = wrenable && reset_n;

    // Byte-merged value of the write target, shared by the array update and the bypass path.
    always_comb begin
        wr_merged = mem_q[writeaddr];
        for (int i = 0; i < NBYTES; i++) begin
            if (byteenable[i]) begin
                wr_merged[8*i +: 8] = writedata[8*i +: 8];
            end
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (wrenable && !(ZR && writeaddr == '0)) begin
            mem_d[writeaddr] = wr_merged;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        readdata1 = mem_q[readaddr1];
        if (BP && wr_live && readaddr1 == writeaddr) begin
            readdata1 = wr_merged;
        end
        if (ZR && readaddr1 == '0) begin
            readdata1 = '0;
        end
    end

    always_comb begin
        readdata2 = mem_q[readaddr2];
        if (BP && wr_live && readaddr2 == writeaddr) begin
            readdata2 = wr_merged;
        end
        if (ZR && readaddr2 == '0) begin
            readdata2 = '0;
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: two instances (zero-reg without bypass, plain entry 0 with bypass)
// driven in parallel from a table of directed vectors plus reset sequences.
module tb_regfile_param;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        wrenable = 1'b0;
    logic [4:0]  writeaddr = '0;
    logic [31:0] writedata = '0;
    logic [3:0]  byteenable = '0;
    logic [4:0]  readaddr1 = '0;
    logic [4:0]  readaddr2 = '0;
    logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_param #(.WIDTH(32), .ADDR_BITS(5), .ZERO_REG(1), .BYPASS(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .wrenable(wrenable), .writeaddr(writeaddr),
        .writedata(writedata), .byteenable(byteenable), .readaddr1(readaddr1),
        .readaddr2(readaddr2), .readdata1(rd1_a), .readdata2(rd2_a)
    );

    regfile_param #(.WIDTH(32), .ADDR_BITS(5), .ZERO_REG(0), .BYPASS(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .wrenable(wrenable), .writeaddr(writeaddr),
        .writedata(writedata), .byteenable(byteenable), .readaddr1(readaddr1),
        .readaddr2(readaddr2), .readdata1(rd1_b), .readdata2(rd2_b)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] pre1_a;
        logic [31:0] pre1_b;
        logic [31:0] post1_a;
        logic [31:0] post2_a;
        logic [31:0] post1_b;
        logic [31:0] post2_b;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    initial begin
        //            we wa  wd            be     ra1 ra2 pre1_a        pre1_b        post1_a       post2_a       post1_b       post2_b
        vecs[0] = '{1'b1, 5'd3,  32'h12345678, 4'hF, 5'd3,  5'd31, 32'h0,        32'h12345678, 32'h12345678, 32'h0,        32'h12345678, 32'h0};
        vecs[1] = '{1'b1, 5'd31, 32'hCAFEF00D, 4'hF, 5'd3,  5'd31, 32'h12345678, 32'h12345678, 32'h12345678, 32'hCAFEF00D, 32'h12345678, 32'hCAFEF00D};
        vecs[2] = '{1'b0, 5'd3,  32'hFFFFFFFF, 4'hF, 5'd3,  5'd3,  32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
        vecs[3] = '{1'b1, 5'd5,  32'h11223344, 4'hF, 5'd5,  5'd3,  32'h0,        32'h11223344, 32'h11223344, 32'h12345678, 32'h11223344, 32'h12345678};
        vecs[4] = '{1'b1, 5'd5,  32'hAABBCCDD, 4'h5, 5'd5,  5'd5,  32'h11223344, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD};
        vecs[5] = '{1'b1, 5'd5,  32'h00000000, 4'h0, 5'd5,  5'd31, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 32'hCAFEF00D, 32'h11BB33DD, 32'hCAFEF00D};
        vecs[6] = '{1'b1, 5'd0,  32'hFFFFFFFF, 4'hF, 5'd0,  5'd0,  32'h0,        32'hFFFFFFFF, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[7] = '{1'b1, 5'd9,  32'h55AA55AA, 4'hF, 5'd9,  5'd0,  32'h0,        32'h55AA55AA, 32'h55AA55AA, 32'h0,        32'h55AA55AA, 32'hFFFFFFFF};
        vecs[8] = '{1'b1, 5'd10, 32'h55AA55AA, 4'h3, 5'd10, 5'd9,  32'h0,        32'h000055AA, 32'h000055AA, 32'h55AA55AA, 32'h000055AA, 32'h55AA55AA};
        vecs[9] = '{1'b1, 5'd3,  32'h00000000, 4'h8, 5'd3,  5'd7,  32'h12345678, 32'h00345678, 32'h00345678, 32'h0,        32'h00345678, 32'h0};

        // Power-on reset
        #1 reset_n = 1'b0;
        readaddr1 = 5'd7;
        readaddr2 = 5'd31;
        #1;
        chk("reset_rd1_a", rd1_a, 32'h0);
        chk("reset_rd2_a", rd2_a, 32'h0);
        chk("reset_rd1_b", rd1_b, 32'h0);
        chk("reset_rd2_b", rd2_b, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset pulse between edges clears stored data immediately
        @(negedge clk);
        wrenable = 1'b1; writeaddr = 5'd7; writedata = 32'hDEADBEEF; byteenable = 4'hF;
        @(posedge clk);
        #1 wrenable = 1'b0;
        #1;
        chk("pre_clear_a", rd1_a, 32'hDEADBEEF);
        chk("pre_clear_b", rd1_b, 32'hDEADBEEF);
        reset_n = 1'b0;
        #1;
        chk("async_clear_a", rd1_a, 32'h0);
        chk("async_clear_b", rd1_b, 32'h0);
        #1 reset_n = 1'b1;

        foreach (vecs[k]) begin
            @(negedge clk);
            wrenable = vecs[k].we; writeaddr = vecs[k].wa; writedata = vecs[k].wd;
            byteenable = vecs[k].be; readaddr1 = vecs[k].ra1; readaddr2 = vecs[k].ra2;
            #1;
            chk($sformatf("v%0d_pre1_a", k), rd1_a, vecs[k].pre1_a);
            chk($sformatf("v%0d_pre1_b", k), rd1_b, vecs[k].pre1_b);
            @(posedge clk);
            #1 wrenable = 1'b0;
            #1;
            chk($sformatf("v%0d_post1_a", k), rd1_a, vecs[k].post1_a);
            chk($sformatf("v%0d_post2_a", k), rd2_a, vecs[k].post2_a);
            chk($sformatf("v%0d_post1_b", k), rd1_b, vecs[k].post1_b);
            chk($sformatf("v%0d_post2_b", k), rd2_b, vecs[k].post2_b);
        end

        // Write strobe held across an edge while reset is low, then released
        @(negedge clk);
        reset_n = 1'b0;
        wrenable = 1'b1; writeaddr = 5'd2; writedata = 32'h1; byteenable = 4'hF;
        readaddr1 = 5'd2; readaddr2 = 5'd3;
        #1;
        chk("coll_bypass_b", rd1_b, 32'h0);
        @(posedge clk);
        #1;
        chk("coll_rd1_a", rd1_a, 32'h0);
        chk("coll_rd1_b", rd1_b, 32'h0);
        chk("coll_lost_a", rd2_a, 32'h0);
        chk("coll_lost_b", rd2_b, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rel_pre_a", rd1_a, 32'h0);
        @(posedge clk);
        #1 wrenable = 1'b0;
        #1;
        chk("rel_post_a", rd1_a, 32'h1);
        chk("rel_post_b", rd1_b, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
